// File: rtl/wash_stage_timer_if.sv
// Control/status bundle between the washer FSM side and the stage timer.
// master drives tick/run/stage/weight; slave (the timer) returns count, flags and water levels.
interface wash_stage_timer_if;
  logic       tick;
  logic       run;
  logic [3:0] stage;
  logic [1:0] weight;
  logic [3:0] sec_left;
  logic       timer_out;
  logic       stage_done;
  logic [7:0] water_target;
  logic [7:0] water_level;

  modport master (
    output tick, run, stage, weight,
    input  sec_left, timer_out, stage_done, water_target, water_level
  );

  modport slave (
    input  tick, run, stage, weight,
    output sec_left, timer_out, stage_done, water_target, water_level
  );
endinterface

// File: rtl/wash_stage_timer.sv
// Per-stage countdown and simulated water level for the washer FSM.
// Loads a duration on entry to a timed stage (next edge); counts down on qualifying 1 Hz ticks; PAUSE freezes everything.
module wash_stage_timer #(
  parameter int WASH_SEC   = 9,
  parameter int DRY_SEC    = 3,
  parameter int LEVEL_BASE = 20,
  parameter int LEVEL_STEP = 10
) (
  input  logic                clk_N,
  input  logic                rst,
  wash_stage_timer_if.slave   bus
);

  localparam logic [3:0] ST_START   = 4'd0;
  localparam logic [3:0] ST_FILL_1  = 4'd1;
  localparam logic [3:0] ST_WASH    = 4'd2;
  localparam logic [3:0] ST_DRAIN_1 = 4'd3;
  localparam logic [3:0] ST_DRY     = 4'd4;
  localparam logic [3:0] ST_FILL_2  = 4'd5;
  localparam logic [3:0] ST_RINSE   = 4'd6;
  localparam logic [3:0] ST_DRAIN_2 = 4'd7;
  localparam logic [3:0] ST_SPIN    = 4'd8;
  localparam logic [3:0] ST_PAUSE   = 4'd11;

  localparam logic [7:0] STEP = 8'(LEVEL_STEP);

  logic [3:0] sec_left_q,     sec_left_d;
  logic       timer_out_q,    timer_out_d;
  logic       stage_done_q,   stage_done_d;
  logic [7:0] water_target_q, water_target_d;
  logic [7:0] water_level_q,  water_level_d;
  logic [3:0] last_stage_q,   last_stage_d;

  logic       timed;
  logic       load;
  logic       qual_tick;
  logic       is_fill;
  logic       is_drain;
  logic [3:0] w4;
  logic [3:0] duration;
  logic [7:0] target_new;
  logic [8:0] fill_sum;
  logic [7:0] fill_level;
  logic [7:0] drain_level;

  always_comb begin
    timed     = (bus.stage >= ST_FILL_1) && (bus.stage <= ST_SPIN);
    load      = timed && (bus.stage != last_stage_q);
    qual_tick = bus.run && bus.tick && !load;
    is_fill   = (bus.stage == ST_FILL_1)  || (bus.stage == ST_FILL_2);
    is_drain  = (bus.stage == ST_DRAIN_1) || (bus.stage == ST_DRAIN_2);
    w4        = {2'b00, bus.weight};

    case (bus.stage)
      ST_FILL_1, ST_FILL_2, ST_DRAIN_1, ST_DRAIN_2: duration = 4'd2 + w4;
      ST_WASH:  duration = 4'(WASH_SEC);
      ST_DRY:   duration = 4'(DRY_SEC);
      ST_RINSE: duration = 4'd4 + w4;
      ST_SPIN:  duration = 4'd5 + w4;
      default:  duration = 4'd0;
    endcase

    target_new = 8'(LEVEL_BASE + LEVEL_STEP * int'(bus.weight));

    // Fill never overshoots the latched target; a level already at/above it just holds.
    fill_sum = {1'b0, water_level_q} + {1'b0, STEP};
    if (water_level_q >= water_target_q)
      fill_level = water_level_q;
    else if (fill_sum >= {1'b0, water_target_q})
      fill_level = water_target_q;
    else
      fill_level = fill_sum[7:0];

    drain_level = (water_level_q < STEP) ? 8'd0 : (water_level_q - STEP);
  end

  always_comb begin
    sec_left_d     = sec_left_q;
    timer_out_d    = timer_out_q;
    stage_done_d   = 1'b0;
    water_target_d = water_target_q;
    water_level_d  = water_level_q;
    last_stage_d   = last_stage_q;

    if (bus.stage == ST_PAUSE) begin
      // everything frozen so the same stage resumes without reload
    end else if (load) begin
      sec_left_d     = duration;
      timer_out_d    = 1'b0;
      last_stage_d   = bus.stage;
      water_target_d = target_new;
    end else if (timed) begin
      if (qual_tick && (sec_left_q != 4'd0)) begin
        sec_left_d = sec_left_q - 4'd1;
        if (sec_left_q == 4'd1) begin
          timer_out_d  = 1'b1;
          stage_done_d = 1'b1;
        end
      end
      if (qual_tick && is_fill)  water_level_d = fill_level;
      if (qual_tick && is_drain) water_level_d = drain_level;
    end else begin
      // START, FINISH, SHUT_DOWN and undefined codes (which act as START)
      sec_left_d   = 4'd0;
      timer_out_d  = 1'b0;
      last_stage_d = ST_START;
      if ((bus.stage == ST_START) || (bus.stage >= 4'd12))
        water_level_d = 8'd0;
    end
  end

  always_ff @(posedge clk_N or posedge rst) begin
    if (rst) begin
      sec_left_q     <= 4'd0;
      timer_out_q    <= 1'b0;
      stage_done_q   <= 1'b0;
      water_target_q <= 8'd0;
      water_level_q  <= 8'd0;
      last_stage_q   <= 4'd0;
    end else begin
      sec_left_q     <= sec_left_d;
      timer_out_q    <= timer_out_d;
      stage_done_q   <= stage_done_d;
      water_target_q <= water_target_d;
      water_level_q  <= water_level_d;
      last_stage_q   <= last_stage_d;
    end
  end

  assign bus.sec_left     = sec_left_q;
  assign bus.timer_out    = timer_out_q;
  assign bus.stage_done   = stage_done_q;
  assign bus.water_target = water_target_q;
  assign bus.water_level  = water_level_q;

endmodule

// File: tb/tb_wash_stage_timer.sv
// Directed bench for wash_stage_timer: inputs change and outputs are checked on the falling clk_N edge.
module tb_wash_stage_timer;
  logic clk_N = 1'b0;
  logic rst   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  wash_stage_timer_if bus();

  wash_stage_timer dut (
    .clk_N (clk_N),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_N = ~clk_N;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: apply tick for one rising edge, return at the next falling edge.
  task automatic cyc(input bit t);
    bus.tick = t;
    @(negedge clk_N);
    bus.tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".sec"},    bus.sec_left,     0);
    chk({tag, ".tout"},   bus.timer_out,    0);
    chk({tag, ".done"},   bus.stage_done,   0);
    chk({tag, ".target"}, bus.water_target, 0);
    chk({tag, ".level"},  bus.water_level,  0);
  endtask

  initial begin
    bus.tick   = 1'b0;
    bus.run    = 1'b0;
    bus.stage  = 4'd0;
    bus.weight = 2'd0;
    @(negedge clk_N);
    @(negedge clk_N);
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: fill, weight 2 -> 4 s, level rises to target 40
    bus.stage = 4'd1; bus.weight = 2'd2; bus.run = 1'b1;
    cyc(0);
    chk("t1.load_sec", bus.sec_left, 4);
    chk("t1.target",   bus.water_target, 40);
    chk("t1.tout0",    bus.timer_out, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk($sformatf("t1.sec%0d", i),   bus.sec_left, 4 - i);
      chk($sformatf("t1.level%0d", i), bus.water_level, 10 * i);
      chk($sformatf("t1.done%0d", i),  bus.stage_done, (i == 4) ? 1 : 0);
    end
    chk("t1.tout", bus.timer_out, 1);
    cyc(1);
    chk("t1.done_once", bus.stage_done, 0);
    chk("t1.sec_nowrap", bus.sec_left, 0);
    chk("t1.level_sat", bus.water_level, 40);
    chk("t1.tout_hold", bus.timer_out, 1);

    // 2: wash, pause, resume without reload
    bus.stage = 4'd2;
    cyc(0);
    chk("t2.load", bus.sec_left, 9);
    chk("t2.tout_clr", bus.timer_out, 0);
    repeat (3) cyc(1);
    chk("t2.after3", bus.sec_left, 6);
    bus.stage = 4'd11; bus.run = 1'b0;
    repeat (5) cyc(1);
    chk("t2.paused", bus.sec_left, 6);
    chk("t2.pause_level", bus.water_level, 40);
    bus.stage = 4'd2; bus.run = 1'b1;
    cyc(0);
    chk("t2.no_reload", bus.sec_left, 6);
    cyc(1);
    chk("t2.resume", bus.sec_left, 5);

    // 3: drain load, then tick coincident with change to dry
    bus.stage = 4'd3;
    cyc(0);
    chk("t3.drain_load", bus.sec_left, 4);
    bus.stage = 4'd4;
    cyc(1);
    chk("t3.load_wins", bus.sec_left, 3);
    chk("t3.level_held", bus.water_level, 40);
    cyc(1); cyc(1);
    chk("t3.tout_early", bus.timer_out, 0);
    cyc(1);
    chk("t3.tout", bus.timer_out, 1);
    chk("t3.done", bus.stage_done, 1);

    // 4: spin, weight changes mid-stage are ignored
    bus.stage = 4'd8; bus.weight = 2'd0;
    cyc(0);
    chk("t4.load", bus.sec_left, 5);
    chk("t4.target", bus.water_target, 20);
    bus.weight = 2'd3;
    repeat (5) cyc(1);
    chk("t4.sec", bus.sec_left, 0);
    chk("t4.tout", bus.timer_out, 1);
    chk("t4.target_kept", bus.water_target, 20);

    // START clears level; FINISH clears count but keeps level
    bus.stage = 4'd0;
    cyc(0);
    chk("start.sec", bus.sec_left, 0);
    chk("start.tout", bus.timer_out, 0);
    chk("start.level", bus.water_level, 0);
    bus.stage = 4'd5; bus.weight = 2'd1;
    cyc(0);
    chk("fill2.load", bus.sec_left, 3);
    repeat (3) cyc(1);
    chk("fill2.level", bus.water_level, 30);
    bus.stage = 4'd9;
    cyc(0);
    chk("finish.sec", bus.sec_left, 0);
    chk("finish.tout", bus.timer_out, 0);
    chk("finish.level", bus.water_level, 30);

    // 5: drain from 30 with weight 0, floor at 0
    bus.stage = 4'd7; bus.weight = 2'd0;
    cyc(0);
    chk("t5.load", bus.sec_left, 2);
    cyc(1);
    chk("t5.level1", bus.water_level, 20);
    chk("t5.tout1", bus.timer_out, 0);
    cyc(1);
    chk("t5.level2", bus.water_level, 10);
    chk("t5.tout2", bus.timer_out, 1);
    cyc(1);
    chk("t5.level3", bus.water_level, 0);
    cyc(1);
    chk("t5.level4", bus.water_level, 0);

    // undefined code behaves as START
    bus.stage = 4'd13;
    cyc(0);
    chk("undef.sec", bus.sec_left, 0);
    chk("undef.tout", bus.timer_out, 0);

    // 6: async reset mid-rinse, then reload
    bus.stage = 4'd6; bus.weight = 2'd1;
    cyc(0);
    chk("t6.load", bus.sec_left, 5);
    cyc(1);
    chk("t6.dec", bus.sec_left, 4);
    rst = 1'b1;
    #1;
    chk_all_zero("t6.async");
    @(negedge clk_N);
    rst = 1'b0;
    cyc(0);
    chk("t6.reload", bus.sec_left, 5);
    chk("t6.target", bus.water_target, 30);

    // run=0 freezes counting in a timed stage
    bus.run = 1'b0;
    repeat (2) cyc(1);
    chk("run0.sec", bus.sec_left, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wash_stage_timer.md
Name: wash_stage_timer

Overview:
- Per-stage timing and water-level controller for the washer FSM.
- Watches the FSM state code, loads a weight-dependent duration on entry to each timed stage, and counts it down on 1 Hz ticks while running.
- Raises a level "stage expired" flag (the FSM's `timer_out`) and keeps the simulated water level for the seven-segment display.

Parameters:
- WASH_SEC, 9: XI_2_WASH duration in seconds (weight-independent).
- DRY_SEC, 3: PIAO_2_DRY duration in seconds (weight-independent).
- LEVEL_BASE, 20: water target for weight 0, in litres.
- LEVEL_STEP, 10: litres added per weight step; also the fill/drain rate per tick.

Ports:
- clk_N  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick  in  1  one-cycle 1 Hz enable, synchronous to clk_N.
- run  in  1  running lamp level; 0 freezes all counting.
- stage  in  4  FSM state code: 0 START, 1 XI_1_IN, 2 XI_2_WASH, 3 PIAO_1_OUT, 4 PIAO_2_DRY, 5 PIAO_3_IN, 6 PIAO_4_RI, 7 TUO_1_OUT, 8 TUO_2_DRY, 9 FINISH, 10 SHUT_DOWN, 11 PAUSE.
- weight  in  2  load weight 0..3; sampled only at stage load.
- sec_left  out  4  seconds remaining in the current stage.
- timer_out  out  1  level; high once the current stage's count has reached 0.
- stage_done  out  1  one-cycle pulse in the cycle timer_out rises.
- water_target  out  8  LEVEL_BASE + LEVEL_STEP*weight, latched at stage load.
- water_level  out  8  simulated drum level in litres.

Behaviour:
- **Reset** (async, rst=1): sec_left=0, timer_out=0, stage_done=0, water_target=0, water_level=0, internal last_stage=0.
- **Timed stages and durations** (w = weight at load):
  - fill (1, 5): 2+w
  - wash (2): WASH_SEC
  - drain (3, 7): 2+w
  - dry (4): DRY_SEC
  - rinse (6): 4+w
  - spin (8): 5+w
  - All durations lie in 2..9, so they fit in 4 bits.
- **Load condition:** stage is timed and stage != last_stage.
  - Takes effect on the next clock edge.
  - Sets sec_left=duration, timer_out=0, last_stage=stage, and latches water_target.
  - Load has priority over a same-cycle tick; no decrement happens that cycle.
- **PAUSE (11):**
  - All registers hold; last_stage is unchanged.
  - Returning to the same timed stage resumes without reload.
- **START (0), FINISH (9), SHUT_DOWN (10):**
  - Clear sec_left, timer_out and last_stage.
  - START additionally clears water_level.
  - FINISH and SHUT_DOWN hold water_level.
- **Countdown:**
  - Occurs when run=1, tick=1, no load that cycle, timed stage and sec_left!=0: sec_left decrements by 1.
  - When sec_left goes 1→0: timer_out=1 on the same edge and stage_done=1 for exactly one cycle.
  - timer_out stays high until the next load or clear.
- **Zero count:** sec_left=0 with further ticks has no effect; there is no wrap and stage_done does not repeat.
- **run=0:** no decrement and no level change, in any stage.
- **Water level** (only on qualifying ticks: run=1, tick=1, no load that cycle):
  - Fill stages (1, 5): level += LEVEL_STEP, saturating at water_target.
  - Drain stages (3, 7): level -= LEVEL_STEP, floored at 0, using 8-bit saturating arithmetic.
  - Other stages: level holds.
- **Other rules:**
  - A weight change mid-stage is ignored until the next load.
  - Undefined stage codes 12..15 behave as START.
  - rst asserted mid-stage returns all outputs to their reset values immediately (asynchronous), regardless of tick.

Test Plan:
1. Reset, then stage=1, weight=2, run=1, 5 ticks → cycle after stage change sec_left=4; after 4 ticks sec_left=0, timer_out=1, stage_done high for exactly one cycle; water_level 0→10→20→30→40, saturating at water_target=40.
2. stage=2, 3 ticks, then stage=11 with run=0 for 5 ticks, then stage=2 with run=1 → sec_left 9→6, holds at 6 throughout the pause, resumes 6→5 with no reload.
3. Tick coincident with a change from stage 3 to stage 4 → sec_left=3 after the edge (load wins); then 3 ticks → timer_out=1.
4. weight=0 at load of stage 8, weight changed to 3 mid-stage → count runs 5→0; water_target unchanged at 20.
5. water_level=30, stage=7, weight=0, 4 ticks → level 20→10→0→0 (floor); timer_out rises after the 2nd tick.
6. rst pulsed between ticks mid-way through stage 6 → all outputs 0 before the next clk_N edge; holding stage=6 after release reloads sec_left=4+w.
